if_fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register and drives its PC and instruction inputs.
- Owns the program counter and issues one outstanding read at a time to instruction memory over a request/response handshake.
- Holds each fetched word until the downstream register accepts it.
- Applies branch redirects, discarding wrong-path fetches. Whenever no valid instruction is available it presents an all-zero bubble (PC 0, instruction 0).

---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 87 ++++++++
 tb/tb_if_fetch_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: control, instruction-memory and IF/ID-facing signals of the fetch stage
interface if_fetch_stage_if #(
  parameter int WORD_LEN = 32
);
  logic                freeze;
  logic                branch_taken;
  logic [WORD_LEN-1:0] branch_addr;
  logic                imem_req;
  logic [WORD_LEN-1:0] imem_addr;
  logic                imem_ready;
  logic                imem_rvalid;
  logic [WORD_LEN-1:0] imem_rdata;
  logic [WORD_LEN-1:0] pc_out;
  logic [WORD_LEN-1:0] instruction_out;
  logic                instr_valid;
  logic                fetch_busy;
  modport master (
    input  freeze, branch_taken, branch_addr, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc_out, instruction_out, instr_valid, fetch_busy
  );
  modport slave (
    output freeze, branch_taken, branch_addr, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc_out, instruction_out, instr_valid, fetch_busy
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner issuing one outstanding imem read, holding each word for IF/ID, with branch kill
module if_fetch_stage #(
  parameter int                  WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter logic [WORD_LEN-1:0] PC_STEP  = WORD_LEN'(4)
) (
  input logic             clk,
  input logic             rst_n,
  if_fetch_stage_if.master bus
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  logic [1:0]          state, state_d;
  logic [WORD_LEN-1:0] pc, pc_d, pc_inc;
  logic [WORD_LEN-1:0] pc_out, pc_out_d;
  logic [WORD_LEN-1:0] ins, ins_d;
  logic                kill, kill_d;
  logic                valid, valid_d;
  logic                busy;
  assign bus.imem_req        = state == S_REQ;
  assign bus.imem_addr       = pc;
  assign bus.pc_out          = pc_out;
  assign bus.instruction_out = ins;
  assign bus.instr_valid     = valid;
  assign bus.fetch_busy      = busy;
  // next-state: a redirect wins over everything; kill marks a wrong-path response still in flight
  always_comb begin
    pc_inc   = pc + PC_STEP;
    state_d  = state;
    pc_d     = pc;
    kill_d   = kill;
    valid_d  = valid;
    pc_out_d = pc_out;
    ins_d    = ins;
    if (bus.branch_taken) begin
      pc_d     = {bus.branch_addr[WORD_LEN-1:2], 2'b00};
      valid_d  = 1'b0;
      pc_out_d = '0;
      ins_d    = '0;
      kill_d   = (state == S_REQ && bus.imem_ready) || (state == S_WAIT && !bus.imem_rvalid);
      state_d  = kill_d ? S_WAIT : S_REQ;
    end else if (state == S_REQ) begin
      state_d = bus.imem_ready ? S_WAIT : S_REQ;
    end else if (state == S_WAIT) begin
      if (bus.imem_rvalid) begin
        kill_d  = 1'b0;
        state_d = kill ? S_REQ : S_HOLD;
        if (!kill) begin
          pc_d     = pc_inc;
          valid_d  = 1'b1;
          pc_out_d = pc_inc;
          ins_d    = bus.imem_rdata;
        end
      end
    end else if (state == S_HOLD) begin
      if (!bus.freeze) begin
        state_d  = S_REQ;
        valid_d  = 1'b0;
        pc_out_d = '0;
        ins_d    = '0;
      end
    end else begin
      state_d = S_REQ;
    end
  end
  // state and registered outputs; busy mirrors the next state so it is registered too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      kill   <= 1'b0;
      valid  <= 1'b0;
      pc_out <= '0;
      ins    <= '0;
      busy   <= 1'b1;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      kill   <= kill_d;
      valid  <= valid_d;
      pc_out <= pc_out_d;
      ins    <= ins_d;
      busy   <= state_d != S_HOLD;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: memory model plus scoreboard of delivered (pc_out, instruction) pairs
module tb_if_fetch_stage;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0, n_fail = 0, delivered = 0, cyc = 0, lat = 0;
  exp_t sbq[$];
  logic [31:0] acc_log[$];
  int del_cyc[$];
  logic ovr_en = 1'b0, seen_dead = 1'b0;
  logic [31:0] ovr_data = '0;
  if_fetch_stage_if #(.WORD_LEN(32)) bus ();
  if_fetch_stage #(.WORD_LEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2) + 32'd1;
  endfunction
  // memory: accepts at the edge where req&ready, answers after lat extra cycles
  initial begin
    logic acc, was_rv, pend;
    logic [31:0] acc_addr, paddr;
    int cnt;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = rst_n && bus.imem_req && bus.imem_ready;
      acc_addr = bus.imem_addr;
      was_rv = bus.imem_rvalid;
      if (acc) acc_log.push_back(acc_addr);
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend = 1'b0;
        bus.imem_rvalid = 1'b0;
      end else begin
        if (was_rv) begin
          bus.imem_rvalid = 1'b0;
          pend = 1'b0;
        end
        if (acc) begin
          pend = 1'b1;
          paddr = acc_addr;
          cnt = lat;
        end
        if (pend && !bus.imem_rvalid) begin
          if (cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = ovr_en ? ovr_data : mdata(paddr);
            ovr_en = 1'b0;
          end else cnt--;
        end
      end
    end
  end
  // monitor: each new valid word is popped from the scoreboard; held words stay stable; bubbles are zero
  initial begin
    logic pv;
    logic [31:0] ppc, pins;
    exp_t e;
    pv = 1'b0;
    ppc = '0;
    pins = '0;
    forever begin
      @(negedge clk);
      if (bus.instr_valid) begin
        if (!pv) begin
          e = sbq.size() > 0 ? sbq.pop_front() : '{pc: 32'hFFFF_FFFF, ins: 32'hFFFF_FFFF};
          chk("sb_pc", bus.pc_out, e.pc);
          chk("sb_ins", bus.instruction_out, e.ins);
          delivered++;
          del_cyc.push_back(cyc);
        end else begin
          chk("hold_pc", bus.pc_out, ppc);
          chk("hold_ins", bus.instruction_out, pins);
        end
      end else begin
        chk("bubble_pc", bus.pc_out, 0);
        chk("bubble_ins", bus.instruction_out, 0);
      end
      if (bus.instruction_out == 32'hDEAD_0000) seen_dead = 1'b1;
      pv = bus.instr_valid;
      ppc = bus.pc_out;
      pins = bus.instruction_out;
    end
  end
  task automatic wait_deliv(input int n);
    int t = 0;
    while (delivered < n && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("deliv_count", delivered, n);
  endtask
  task automatic wait_acc();
    int t = 0;
    while (!(bus.imem_req && bus.imem_ready) && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("acc_seen", 32'(bus.imem_req && bus.imem_ready), 1);
    @(negedge clk);
    #1;
  endtask
  task automatic pulse_branch(input logic [31:0] a);
    bus.branch_taken = 1'b1;
    bus.branch_addr = a;
    @(negedge clk);
    #1;
    bus.branch_taken = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = '0;
    bus.imem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_pc_out", bus.pc_out, 0);
    chk("rst_ins", bus.instruction_out, 0);
    chk("rst_busy", 32'(bus.fetch_busy), 1);
    sbq.push_back('{pc: 32'h4, ins: 32'hA000_0001});
    sbq.push_back('{pc: 32'h8, ins: 32'hA000_0002});
    sbq.push_back('{pc: 32'hC, ins: 32'hA000_0003});
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", bus.imem_addr, 0);
    wait_deliv(3);
    bus.freeze = 1'b1;
    chk("t1_addr0", acc_log[0], 32'h0);
    chk("t1_addr1", acc_log[1], 32'h4);
    chk("t1_addr2", acc_log[2], 32'h8);
    chk("t1_gap01", del_cyc[1] - del_cyc[0], 3);
    chk("t1_gap12", del_cyc[2] - del_cyc[1], 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t2_valid", 32'(bus.instr_valid), 1);
      chk("t2_pc", bus.pc_out, 32'hC);
      chk("t2_ins", bus.instruction_out, 32'hA000_0003);
      chk("t2_noreq", 32'(bus.imem_req), 0);
      chk("t2_busy", 32'(bus.fetch_busy), 0);
    end
    sbq.push_back('{pc: 32'h10, ins: 32'hA000_0004});
    bus.freeze = 1'b0;
    wait_deliv(4);
    bus.freeze = 1'b1;
    chk("t2_next_addr", acc_log[$], 32'hC);
    lat = 3;
    ovr_en = 1'b1;
    ovr_data = 32'hDEAD_0000;
    bus.freeze = 1'b0;
    wait_acc();
    pulse_branch(32'h103);
    lat = 0;
    chk("t3_wait_noreq", 32'(bus.imem_req), 0);
    sbq.push_back('{pc: 32'h104, ins: 32'hA000_0041});
    wait_deliv(5);
    bus.freeze = 1'b1;
    chk("t3_dead_sent", 32'(ovr_en), 0);
    chk("t3_no_dead", 32'(seen_dead), 0);
    chk("t3_killed_addr", acc_log[$-1], 32'h10);
    chk("t3_target_addr", acc_log[$], 32'h100);
    bus.freeze = 1'b0;
    @(negedge clk);
    #1;
    chk("t4a_req", 32'(bus.imem_req), 1);
    chk("t4a_addr", bus.imem_addr, 32'h104);
    pulse_branch(32'h200);
    sbq.push_back('{pc: 32'h204, ins: 32'hA000_0081});
    wait_deliv(6);
    bus.freeze = 1'b1;
    chk("t4a_old_addr", acc_log[$-1], 32'h104);
    chk("t4a_new_addr", acc_log[$], 32'h200);
    bus.freeze = 1'b0;
    wait_acc();
    pulse_branch(32'h300);
    chk("t4b_req", 32'(bus.imem_req), 1);
    chk("t4b_addr", bus.imem_addr, 32'h300);
    sbq.push_back('{pc: 32'h304, ins: 32'hA000_00C1});
    wait_deliv(7);
    bus.freeze = 1'b1;
    chk("t4b_dropped_addr", acc_log[$-1], 32'h204);
    pulse_branch(32'hFFFF_FFFF);
    chk("t5_valid", 32'(bus.instr_valid), 0);
    chk("t5_req", 32'(bus.imem_req), 1);
    chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    sbq.push_back('{pc: 32'h0, ins: 32'hE000_0000});
    sbq.push_back('{pc: 32'h4, ins: 32'hA000_0001});
    bus.freeze = 1'b0;
    wait_deliv(9);
    bus.freeze = 1'b1;
    chk("t5_top_addr", acc_log[$-1], 32'hFFFF_FFFC);
    chk("t5_wrap_addr", acc_log[$], 32'h0);
    lat = 3;
    bus.freeze = 1'b0;
    wait_acc();
    pulse_branch(32'h400);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.instr_valid), 0);
    chk("t6_pc_out", bus.pc_out, 0);
    chk("t6_addr", bus.imem_addr, 0);
    chk("t6_req", 32'(bus.imem_req), 1);
    lat = 0;
    sbq.push_back('{pc: 32'h4, ins: 32'hA000_0001});
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_deliv(10);
    bus.freeze = 1'b1;
    chk("t6_first_addr", acc_log[$], 32'h0);
    chk("sb_left", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
